// File: rtl/hs_dpath_pkg.sv
// Shared types and helpers for the hs_dpath datapath blocks.
package hs_dpath_pkg;

    typedef enum logic {HS_PISO_IDLE, HS_PISO_SHIFT} hs_dpath_piso_state_e;

    // Width of a counter that must hold 0..n inclusive, never narrower than 1 bit.
    function automatic int hs_dpath_cnt_w(int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hs_dpath_piso_hs.sv
// hs_dpath_piso_hs: parallel-in, serial-out shift register with valid/ready
// handshakes on both sides. One input beat loads up to DEPTH elements; they are
// emitted element 0 first, one per accepted output beat.
// Optional build macro HS_DPATH_PISO_B2B_EN: accept the next vector on the same
// edge that retires the last element of the current one (no idle bubble).
module hs_dpath_piso_hs
    import hs_dpath_pkg::*;
#(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = '0,
    parameter int       DEPTH       = 4
) (
    input  logic                                   clk,
    input  logic                                   aresetn,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  DATA_TYPE                               din [DEPTH],
    input  logic [hs_dpath_cnt_w(DEPTH)-1:0]       in_len,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output DATA_TYPE                               dout,
    output logic                                   out_last,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] out_idx,
    output logic                                   busy
);

    localparam int LEN_W = hs_dpath_cnt_w(DEPTH);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

    hs_dpath_piso_state_e state_reg;
    logic [LEN_W-1:0]     rem_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic                 last_reg;
    DATA_TYPE             slot_reg  [DEPTH];
    DATA_TYPE             shift_val [DEPTH];

    logic [LEN_W-1:0]     len_clamped;
    logic                 in_acc;
    logic                 out_acc;
    logic                 load;
    logic                 retire;

    // Oversized requests are clamped to the storage depth.
    assign len_clamped = (in_len > DEPTH_LEN) ? DEPTH_LEN : in_len;

    assign out_valid = (state_reg == HS_PISO_SHIFT);
    assign busy      = (state_reg == HS_PISO_SHIFT);
    assign dout      = slot_reg[0];
    assign out_last  = last_reg;
    assign out_idx   = idx_reg;

`ifdef HS_DPATH_PISO_B2B_EN
    // Also ready while the final element is being taken, so the next vector
    // loads on the very edge that retires the current one.
    assign in_ready = (state_reg == HS_PISO_IDLE) ||
                      ((state_reg == HS_PISO_SHIFT) && out_ready && (rem_reg == LEN_W'(1)));
`else
    assign in_ready = (state_reg == HS_PISO_IDLE);
`endif

    assign in_acc  = in_valid && in_ready;
    assign out_acc = out_valid && out_ready;
    // A zero-length vector is consumed but never stored.
    assign load    = in_acc && (len_clamped != '0);
    assign retire  = out_acc && (rem_reg == LEN_W'(1));

    // Value each slot takes on a shift: its upper neighbour, or the reset value
    // for the topmost slot that is vacated.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
            if (gi == DEPTH - 1) begin : g_top
                assign shift_val[gi] = RESET_VALUE;
            end else begin : g_mid
                assign shift_val[gi] = slot_reg[gi + 1];
            end
        end
    endgenerate

    // Storage: load a whole vector, shift down per accepted beat, and clear
    // everything once the vector is finished so dout idles at RESET_VALUE.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_reg[i] <= RESET_VALUE;
            end
        end else if (load) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_reg[i] <= din[i];
            end
        end else if (retire) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_reg[i] <= RESET_VALUE;
            end
        end else if (out_acc) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_reg[i] <= shift_val[i];
            end
        end
    end

    // Control FSM with remaining-count, output index and last flag registered
    // so no input reaches the output side combinationally.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg <= HS_PISO_IDLE;
            rem_reg   <= '0;
            idx_reg   <= '0;
            last_reg  <= 1'b0;
        end else if (load) begin
            state_reg <= HS_PISO_SHIFT;
            rem_reg   <= len_clamped;
            idx_reg   <= '0;
            last_reg  <= (len_clamped == LEN_W'(1));
        end else if (retire) begin
            state_reg <= HS_PISO_IDLE;
            rem_reg   <= '0;
            idx_reg   <= '0;
            last_reg  <= 1'b0;
        end else if (out_acc) begin
            rem_reg   <= rem_reg - LEN_W'(1);
            idx_reg   <= idx_reg + IDX_W'(1);
            last_reg  <= (rem_reg == LEN_W'(2));
        end
    end

endmodule

// File: tb/tb_hs_dpath_piso_hs.sv
// Self-checking bench for hs_dpath_piso_hs: a DEPTH=4 instance checked against a
// queue-based beat model, plus a DEPTH=1 instance.
`timescale 1ns/1ps
module tb_hs_dpath_piso_hs;

    typedef logic [7:0] byte_t;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [DEPTH-1:0][7:0] v;
        logic [2:0]            len;
    } vec_t;

    typedef struct packed {
        byte_t      d;
        logic [1:0] idx;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  aresetn;
    // DEPTH = 4 instance
    logic  in_valid, in_ready, out_valid, out_ready, out_last, busy;
    byte_t din [DEPTH];
    logic [2:0] in_len;
    byte_t dout;
    logic [1:0] out_idx;
    // DEPTH = 1 instance
    logic  in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
    byte_t din1 [1];
    logic [0:0] in_len1;
    byte_t dout1;
    logic [0:0] out_idx1;

    hs_dpath_piso_hs #(.DATA_TYPE(byte_t), .RESET_VALUE(8'h00), .DEPTH(DEPTH)) dut (
        .clk(clk), .aresetn(aresetn),
        .in_valid(in_valid), .in_ready(in_ready), .din(din), .in_len(in_len),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .out_last(out_last), .out_idx(out_idx), .busy(busy)
    );

    hs_dpath_piso_hs #(.DATA_TYPE(byte_t), .RESET_VALUE(8'h00), .DEPTH(1)) dut1 (
        .clk(clk), .aresetn(aresetn),
        .in_valid(in_valid1), .in_ready(in_ready1), .din(din1), .in_len(in_len1),
        .out_valid(out_valid1), .out_ready(out_ready1), .dout(dout1),
        .out_last(out_last1), .out_idx(out_idx1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;

    beat_t exp_q  [$];   // beats still owed by the DUT, in order
    vec_t  pend_q [$];   // vectors waiting to be offered
    bit    trace_q[$];   // out_valid per cycle of the last stream run

    function automatic vec_t mk_vec(byte_t b0, byte_t b1, byte_t b2, byte_t b3, int len);
        vec_t v;
        v.v[0] = b0; v.v[1] = b1; v.v[2] = b2; v.v[3] = b3;
        v.len  = 3'(len);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        return mk_vec(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(0, 7)));
    endfunction

    // An accepted vector owes min(len, DEPTH) beats, element 0 first.
    function automatic void model_accept(vec_t v);
        int    n;
        beat_t b;
        n = (int'(v.len) > DEPTH) ? DEPTH : int'(v.len);
        for (int i = 0; i < n; i++) begin
            b.d    = v.v[i];
            b.idx  = 2'(i);
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
    endfunction

    // Ready when nothing is owed; with back-to-back enabled also when the single
    // owed beat is being taken this cycle.
    function automatic bit model_ready(bit ordy);
`ifdef HS_DPATH_PISO_B2B_EN
        return (exp_q.size() == 0) || ((exp_q.size() == 1) && ordy);
`else
        return (exp_q.size() == 0) || (ordy && 1'b0);
`endif
    endfunction

    task automatic test_reset();
        aresetn   = 1'b0;
        in_valid  = 1'b0; out_ready  = 1'b0; in_len  = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; in_len1 = '0;
        for (int i = 0; i < DEPTH; i++) din[i] = 8'($urandom);
        din1[0] = 8'($urandom);
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            out_idx !== 2'd0 || busy !== 1'b0 || dout !== 8'h00)
        begin
            errors++;
            $display("FAIL reset4: rdy=%b v=%b last=%b idx=%0d busy=%b d=%h, want 1 0 0 0 0 00",
                     in_ready, out_valid, out_last, out_idx, busy, dout);
        end
        checks++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || out_last1 !== 1'b0 ||
            out_idx1 !== 1'b0 || busy1 !== 1'b0 || dout1 !== 8'h00)
        begin
            errors++;
            $display("FAIL reset1: rdy=%b v=%b last=%b idx=%0d busy=%b d=%h, want 1 0 0 0 0 00",
                     in_ready1, out_valid1, out_last1, out_idx1, busy1, dout1);
        end
        aresetn = 1'b1;
        $display("test_reset done");
    endtask

    // Offers every vector in pend_q and checks each cycle against the model.
    // rmode: 0 = out_ready held 1, 1 = pattern 1,0,0 repeating, 2 = random.
    task automatic test_stream(string name, int rmode);
        int    cyc = 0;
        bit    exp_rdy;
        beat_t b;
        trace_q.delete();
        while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < 400) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() > 0) begin
                b = exp_q[0];
                if (out_valid !== 1'b1 || dout !== b.d || out_idx !== b.idx ||
                    out_last !== b.last || busy !== 1'b1)
                begin
                    errors++;
                    $display("FAIL %s beat c%0d: v=%b d=%h idx=%0d last=%b busy=%b, want v=1 d=%h idx=%0d last=%b busy=1",
                             name, cyc, out_valid, dout, out_idx, out_last, busy, b.d, b.idx, b.last);
                end else begin
                    $display("%s c%0d: beat d=%h idx=%0d last=%b ready=%b",
                             name, cyc, dout, out_idx, out_last, out_ready);
                end
            end else if (out_valid !== 1'b0 || busy !== 1'b0 || dout !== 8'h00) begin
                errors++;
                $display("FAIL %s idle c%0d: v=%b busy=%b d=%h, want 0 0 00",
                         name, cyc, out_valid, busy, dout);
            end
            trace_q.push_back(out_valid);
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (pend_q.size() > 0 && (rmode != 2 || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                for (int i = 0; i < DEPTH; i++) din[i] = pend_q[0].v[i];
                in_len = pend_q[0].len;
            end else begin
                in_valid = 1'b0;
                in_len   = 3'($urandom);
            end
            #1;
            exp_rdy = model_ready(out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL %s in_ready c%0d: got %b want %b", name, cyc, in_ready, exp_rdy);
            end
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && exp_rdy) model_accept(pend_q.pop_front());
            cyc++;
        end
        if (cyc >= 400) begin
            errors++;
            $display("FAIL %s timeout: %0d beats and %0d vectors left", name, exp_q.size(), pend_q.size());
            exp_q.delete();
            pend_q.delete();
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || dout !== 8'h00) begin
            errors++;
            $display("FAIL %s end: v=%b rdy=%b busy=%b d=%h, want 0 1 0 00",
                     name, out_valid, in_ready, busy, dout);
        end
        trace_q.push_back(out_valid);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1'b1; in_len = 3'd4; out_ready = 1'b1;
        din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || dout !== 8'h33 || out_idx !== 2'd2) begin
            errors++;
            $display("FAIL rst_mid pre: v=%b d=%h idx=%0d, want 1 33 2", out_valid, dout, out_idx);
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dout !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1 ||
            out_last !== 1'b0 || out_idx !== 2'd0)
        begin
            errors++;
            $display("FAIL rst_mid async: v=%b d=%h busy=%b rdy=%b last=%b idx=%0d, want 0 00 0 1 0 0",
                     out_valid, dout, busy, in_ready, out_last, out_idx);
        end
        $display("test_async_reset: outputs cleared without a clock edge");
        @(negedge clk);
        aresetn = 1'b1;
        exp_q.delete();
        pend_q.push_back(mk_vec(8'hAA, 8'hBB, 8'hCC, 8'hDD, 4));
        test_stream("post_reset", 0);
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int lastv = -1;
        int ones  = 0;
        int gaps  = 0;
        int exp_gaps;
        pend_q.push_back(mk_vec(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4));
        pend_q.push_back(mk_vec(8'hB0, 8'hB1, 8'hB2, 8'hB3, 4));
        test_stream("b2b", 0);
        foreach (trace_q[i]) begin
            if (trace_q[i]) begin
                if (first < 0) first = i;
                lastv = i;
                ones++;
            end
        end
        for (int i = first; i <= lastv && first >= 0; i++) if (!trace_q[i]) gaps++;
`ifdef HS_DPATH_PISO_B2B_EN
        exp_gaps = 0;
`else
        exp_gaps = 1;
`endif
        checks++;
        if (ones !== 8 || gaps !== exp_gaps) begin
            errors++;
            $display("FAIL b2b spacing: beats=%0d gaps=%0d, want 8 and %0d", ones, gaps, exp_gaps);
        end
        $display("test_back_to_back: beats=%0d gaps=%0d", ones, gaps);
    endtask

    task automatic test_depth1();
        byte_t v;
        for (int k = 0; k < 3; k++) begin
            v = 8'($urandom);
            @(negedge clk);
            checks++;
            if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
                errors++;
                $display("FAIL d1 idle%0d: rdy=%b v=%b, want 1 0", k, in_ready1, out_valid1);
            end
            in_valid1 = 1'b1; din1[0] = v; in_len1 = 1'b1; out_ready1 = 1'b1;
            @(negedge clk);
            in_valid1 = 1'b0;
            checks++;
            if (out_valid1 !== 1'b1 || dout1 !== v || out_last1 !== 1'b1 || out_idx1 !== 1'b0 || busy1 !== 1'b1) begin
                errors++;
                $display("FAIL d1 beat%0d: v=%b d=%h last=%b idx=%0d busy=%b, want 1 %h 1 0 1",
                         k, out_valid1, dout1, out_last1, out_idx1, busy1, v);
            end else begin
                $display("depth1 vec%0d: beat d=%h last=%b idx=%0d", k, dout1, out_last1, out_idx1);
            end
            @(negedge clk);
            checks++;
            if (out_valid1 !== 1'b0 || dout1 !== 8'h00) begin
                errors++;
                $display("FAIL d1 after%0d: v=%b d=%h, want 0 00", k, out_valid1, dout1);
            end
        end
    endtask

    initial begin
        test_reset();
        pend_q.push_back(mk_vec(8'h11, 8'h22, 8'h33, 8'h44, 4));
        test_stream("full", 0);
        pend_q.push_back(mk_vec(8'h11, 8'h22, 8'h33, 8'h44, 4));
        test_stream("stall", 1);
        pend_q.push_back(mk_vec(8'h11, 8'h22, 8'h33, 8'h44, 2));
        pend_q.push_back(mk_vec(8'h55, 8'h66, 8'h77, 8'h88, 0));
        pend_q.push_back(mk_vec(8'h99, 8'hAA, 8'hBB, 8'hCC, 7));
        test_stream("lens", 0);
        test_async_reset();
        test_back_to_back();
        for (int i = 0; i < 25; i++) pend_q.push_back(rand_vec());
        test_stream("random", 2);
        test_depth1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hs_dpath_piso_hs.md
Name: hs_dpath_piso_hs

Overview:
- Parameterized parallel-in, serial-out shift register with valid/ready handshakes on both sides.
- Loads a vector of up to DEPTH elements of a generic DATA_TYPE in one input beat, then emits them one element per accepted output beat, element 0 first.
- It is the serializing counterpart of the datapath tapped shift register (serial-in, parallel-out).
- Used at datapath boundaries that narrow a parallel bus to a streaming interface.

Parameters:
DATA_TYPE, logic, element type for din/dout
RESET_VALUE, 1'b0, value of every storage element and dout after reset and of vacated slots after shift
DEPTH, 4, maximum elements per vector; legal range 1:65535

Ports:
clk  input  1  clock, rising edge
aresetn  input  1  asynchronous reset, active low
in_valid  input  1  input vector valid
in_ready  output  1  block can accept a vector this cycle
din  input  DATA_TYPE [DEPTH] (unpacked)  parallel input vector; din[0] leaves first
in_len  input  $clog2(DEPTH+1)  number of elements to emit, 0..DEPTH
out_valid  output  1  dout holds a valid element
out_ready  input  1  downstream accepts dout
dout  output  DATA_TYPE  current serial element
out_last  output  1  dout is the final element of the vector
out_idx  output  $clog2(DEPTH) (min 1)  index of dout within the vector
busy  output  1  state is SHIFT

Behaviour:
- Clocking and reset: single clock domain, clk. aresetn is asynchronous assert, active low.
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0; out_last = 0; out_idx = 0; busy = 0.
  - Every storage slot and dout = RESET_VALUE; remaining count = 0.
- Input accept: in_valid && in_ready. Output accept: out_valid && out_ready.
- States: IDLE and SHIFT.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On input accept with in_len >= 1: store din[0..DEPTH-1], rem = in_len, out_idx = 0, go to SHIFT.
  - On input accept with in_len = 0: vector consumed and dropped; stay IDLE; no output beat.
  - in_len > DEPTH: clamped to DEPTH.
- SHIFT:
  - out_valid = 1; dout = slot[0]; out_last = (rem == 1).
  - On output accept: slots shift down by one (slot[i] <= slot[i+1]); slot[DEPTH-1] <= RESET_VALUE; rem--; out_idx++.
  - On output accept with rem == 1: return to IDLE; dout becomes RESET_VALUE.
  - out_valid and dout are held stable while out_ready = 0. Full AXI-style stability: no retraction, no data change.
- Latency:
  - First element valid the cycle after input accept (registered output).
  - Throughput is one element per cycle under continuous out_ready.
- Outputs are driven directly from registers; there is no combinational path from in_valid or out_ready to out_valid or dout.
- Reset mid-vector: the vector is discarded immediately; all outputs return to their reset values asynchronously.
- DEPTH = 1: every vector yields a single beat with out_last = 1 and out_idx = 0.

Optional Feature:
- Macro: HS_DPATH_PISO_B2B_EN.
- Defined: in SHIFT, in_ready = out_ready && (rem == 1). Input accept in that cycle loads the new vector in the same edge that retires the last element, giving zero bubble between vectors. A loaded in_len = 0 returns to IDLE.
- Undefined: in_ready = 1 only in IDLE. One idle cycle separates consecutive vectors.

Decomposition:
- Shared package hs_dpath_pkg holds:
  - typedef enum logic {HS_PISO_IDLE, HS_PISO_SHIFT} hs_dpath_piso_state_e;
  - function hs_dpath_cnt_w(int n), returning max(1, $clog2(n+1)), for counter widths.
- No sub-module. The storage array, down-counter and 2-state FSM are inline; the expected size is about 150 lines.

Test Plan (DATA_TYPE = logic [7:0], DEPTH = 4):
1. Reset, then din = {8'h11, 8'h22, 8'h33, 8'h44}, in_len = 4, out_ready held 1 -> dout 11, 22, 33, 44 on 4 consecutive cycles starting 1 cycle after accept; out_idx 0..3; out_last only with 44; then IDLE with in_ready = 1.
2. Same vector, out_ready toggling 1, 0, 0, 1, ... -> dout and out_valid hold during stalls; exactly 4 beats in order; no duplicates or drops.
3. in_len = 2, then in_len = 0, then in_len = 7 -> beats 11, 22 (last on 22); in_len = 0 vector consumed with no beat and in_ready stays 1; in_len = 7 clamped to 4 beats.
4. aresetn pulsed low after the 2nd beat of a 4-element vector -> out_valid = 0, dout = 00, busy = 0 immediately; the next vector serializes from index 0.
5. Back-to-back vectors {A0..A3} and {B0..B3}, in_valid held, out_ready = 1:
   - With HS_DPATH_PISO_B2B_EN: B0 directly follows A3 with 8 beats over 8 cycles.
   - Without the macro: one cycle with out_valid = 0 between A3 and B0.
6. DEPTH = 1 build, three vectors with out_ready = 1 -> each produces one beat with out_last = 1 and out_idx = 0.
